// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// Module : mem_ctrl_pkg
// Brief  : Shared defaults, beat-counter width and FSM state encoding for the
//          burst memory access controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;
    localparam int AW_DEF = 9;
    localparam int DW_DEF = 16;
    localparam int BEAT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_e;
endpackage

`default_nettype wire

// File: rtl/mem_burst_cnt.sv
// ============================================================================
// Module : mem_burst_cnt
// Brief  : Latched burst base address and beat counter; produces the current
//          beat address (modulo 2^AW) and a last-beat flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_burst_cnt
    import mem_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              load_i,
    input  logic [AW-1:0]     base_i,
    input  logic [BEAT_W-1:0] len_i,
    input  logic              adv_i,
    output logic [AW-1:0]     addr_o,
    output logic              last_o
);
    logic [AW-1:0]     base_q, base_d;
    logic [BEAT_W-1:0] len_q,  len_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        beat_d = beat_q;
        if (load_i) begin
            base_d = base_i;
            len_d  = len_i;
            beat_d = '0;
        end else if (adv_i) begin
            beat_d = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            base_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            beat_q <= beat_d;
        end
    end

    // Address wraps naturally in AW bits.
    assign addr_o = base_q + {{(AW-BEAT_W){1'b0}}, beat_q};
    assign last_o = (beat_q == len_q);
endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module : mem_access_ctrl
// Brief  : CPU burst (1..4 beat) read/write controller for a single-port
//          memory. Optional macro MEM_WRAP_ERR_EN rejects wrapping bursts.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [AW-1:0]     req_addr_i,
    input  logic [BEAT_W-1:0] req_len_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [DW-1:0]     wdata_i,
    output logic              rvalid_o,
    output logic [DW-1:0]     rdata_o,
    output logic              done_o,
    output logic              err_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_din_o,
    input  logic [DW-1:0]     mem_dout_i
);
    state_e        state_q, state_d;
    logic          pend_q, pend_d;
    logic          pend_last_q, pend_last_d;
    logic          load, adv, last, wrap_err;
    logic [AW-1:0] beat_addr;

    mem_burst_cnt #(.AW(AW)) u_cnt (
        .clk    (clk),
        .rst_b  (rst_b),
        .load_i (load),
        .base_i (req_addr_i),
        .len_i  (req_len_i),
        .adv_i  (adv),
        .addr_o (beat_addr),
        .last_o (last)
    );

`ifdef MEM_WRAP_ERR_EN
    logic err_q;
    assign wrap_err = ({1'b0, req_addr_i} + {{(AW+1-BEAT_W){1'b0}}, req_len_i})
                      > {1'b0, {AW{1'b1}}};

    always_ff @(posedge clk) begin
        if (!rst_b) err_q <= 1'b0;
        else        err_q <= load && wrap_err;
    end
    assign err_o = err_q;
`else
    assign wrap_err = 1'b0;
    assign err_o    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        wready_o    = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        load        = 1'b0;
        adv         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    load = 1'b1;
                    // A rejected (wrapping) request is consumed but stays in IDLE.
                    if (!wrap_err) state_d = req_we_i ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                mem_read_o = 1'b1;
                adv        = 1'b1;
                if (last) state_d = ST_IDLE;
            end
            ST_WR: begin
                wready_o = 1'b1;
                if (wvalid_i) begin
                    mem_write_o = 1'b1;
                    adv         = 1'b1;
                    if (last) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pend_d      = mem_read_o;
        pend_last_d = mem_read_o && last;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
        end
    end

    assign mem_addr_o = (state_q != ST_IDLE) ? beat_addr : '0;
    assign mem_din_o  = (state_q == ST_WR) ? wdata_i : '0;
    assign rvalid_o   = pend_q;
    assign rdata_o    = pend_q ? mem_dout_i : '0;
    assign done_o     = (state_q == ST_WR && wvalid_i && last) || (pend_q && pend_last_q);
endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module : tb_mem_access_ctrl
// Brief  : Table-driven cycle vectors for mem_access_ctrl with a behavioural
//          memory; expectations are hand-derived. Honours MEM_WRAP_ERR_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;
    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_b, req_valid, req_ready, req_we, wvalid, wready;
    logic [AW-1:0] req_addr, mem_addr;
    logic [1:0]    req_len;
    logic [DW-1:0] wdata, rdata, mem_din, mem_dout;
    logic          rvalid, done, err, mem_write, mem_read;

    logic [DW-1:0] mem [512];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_len_i   (req_len),
        .wvalid_i    (wvalid),
        .wready_o    (wready),
        .wdata_i     (wdata),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .done_o      (done),
        .err_o       (err),
        .mem_write_o (mem_write),
        .mem_read_o  (mem_read),
        .mem_addr_o  (mem_addr),
        .mem_din_o   (mem_din),
        .mem_dout_i  (mem_dout)
    );

    // Behavioural synchronous memory: read data valid the cycle after mem_read.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_din;
        if (mem_read)  mem_dout <= mem[mem_addr];
    end

    typedef struct {
        logic          rst_b, rv, we;
        logic [AW-1:0] addr;
        logic [1:0]    len;
        logic          wv;
        logic [DW-1:0] wd;
        logic          rdy, rd, wr, wrdy;
        logic [AW-1:0] maddr;
        logic [DW-1:0] din;
        logic          rval;
        logic [DW-1:0] rdat;
        logic          done, err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rb, rv, we, input logic [AW-1:0] a, input logic [1:0] l,
                       input logic wv, input logic [DW-1:0] wd,
                       input logic rdy, rd, wr, wrdy, input logic [AW-1:0] ma,
                       input logic [DW-1:0] din, input logic rval, input logic [DW-1:0] rdat,
                       input logic dn, er);
        vec_t v;
        v.rst_b = rb; v.rv = rv; v.we = we; v.addr = a; v.len = l; v.wv = wv; v.wd = wd;
        v.rdy = rdy; v.rd = rd; v.wr = wr; v.wrdy = wrdy; v.maddr = ma; v.din = din;
        v.rval = rval; v.rdat = rdat; v.done = dn; v.err = er;
        tbl.push_back(v);
    endtask

    // Idle cycle, no request, expect quiet outputs with req_ready high.
    task automatic add_idle();
        add(1,0,0,9'h000,2'd0,0,16'h0, 1,0,0,0,9'h000,16'h0,0,16'h0,0,0);
    endtask

    task automatic check_mem(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        n_vec++;
        if (mem[a] !== exp) begin
            n_bad++;
            $display("FAIL %s: mem[%03h] got %04h expected %04h", name, a, mem[a], exp);
        end
    endtask

    initial begin
        logic [31:0] got, exp;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0;
        mem_dout = 16'h0;
        mem[9'h010] = 16'hA0A0; mem[9'h011] = 16'hB1B1;
        mem[9'h012] = 16'hC2C2; mem[9'h013] = 16'hD3D3;
        mem[9'h1FE] = 16'hE1E1; mem[9'h1FF] = 16'hE2E2;
        mem[9'h000] = 16'hE3E3; mem[9'h001] = 16'hE4E4;

        //   rb rv we addr    len wv wd        rdy rd wr wrdy maddr  din      rval rdat    dn er
        // Reset state, then 4-beat read at 0x010.
        add_idle();
        add(1,1,0,9'h010,2'd3,0,16'h0,      1,0,0,0,9'h000,16'h0,    0,16'h0,    0,0);
        add(1,0,0,9'h000,2'd0,0,16'h0,      0,1,0,0,9'h010,16'h0,    0,16'h0,    0,0);
        add(1,0,0,9'h000,2'd0,0,16'h0,      0,1,0,0,9'h011,16'h0,    1,16'hA0A0, 0,0);
        add(1,0,0,9'h000,2'd0,0,16'h0,      0,1,0,0,9'h012,16'h0,    1,16'hB1B1, 0,0);
        add(1,0,0,9'h000,2'd0,0,16'h0,      0,1,0,0,9'h013,16'h0,    1,16'hC2C2, 0,0);
        add(1,0,0,9'h000,2'd0,0,16'h0,      1,0,0,0,9'h000,16'h0,    1,16'hD3D3, 1,0);
        add_idle();
        // 2-beat write at 0x1F0 with wvalid 1,0,1.
        add(1,1,1,9'h1F0,2'd1,0,16'h0,      1,0,0,0,9'h000,16'h0,    0,16'h0,    0,0);
        add(1,0,0,9'h000,2'd0,1,16'h1111,   0,0,1,1,9'h1F0,16'h1111, 0,16'h0,    0,0);
        add(1,0,0,9'h000,2'd0,0,16'h0,      0,0,0,1,9'h1F1,16'h0,    0,16'h0,    0,0);
        add(1,0,0,9'h000,2'd0,1,16'h2222,   0,0,1,1,9'h1F1,16'h2222, 0,16'h0,    1,0);
        add_idle();
        // Read at 0x1FE len 3: wraps, or is rejected with the macro.
        add(1,1,0,9'h1FE,2'd3,0,16'h0,      1,0,0,0,9'h000,16'h0,    0,16'h0,    0,0);
`ifdef MEM_WRAP_ERR_EN
        add(1,0,0,9'h000,2'd0,0,16'h0,      1,0,0,0,9'h000,16'h0,    0,16'h0,    0,1);
        add_idle();
        add_idle();
`else
        add(1,0,0,9'h000,2'd0,0,16'h0,      0,1,0,0,9'h1FE,16'h0,    0,16'h0,    0,0);
        add(1,0,0,9'h000,2'd0,0,16'h0,      0,1,0,0,9'h1FF,16'h0,    1,16'hE1E1, 0,0);
        add(1,0,0,9'h000,2'd0,0,16'h0,      0,1,0,0,9'h000,16'h0,    1,16'hE2E2, 0,0);
        add(1,0,0,9'h000,2'd0,0,16'h0,      0,1,0,0,9'h001,16'h0,    1,16'hE3E3, 0,0);
        add(1,0,0,9'h000,2'd0,0,16'h0,      1,0,0,0,9'h000,16'h0,    1,16'hE4E4, 1,0);
`endif
        add_idle();
        // Back-to-back reads: second request held until the final-rvalid cycle.
        add(1,1,0,9'h010,2'd1,0,16'h0,      1,0,0,0,9'h000,16'h0,    0,16'h0,    0,0);
        add(1,0,0,9'h000,2'd0,0,16'h0,      0,1,0,0,9'h010,16'h0,    0,16'h0,    0,0);
        add(1,1,0,9'h012,2'd0,0,16'h0,      0,1,0,0,9'h011,16'h0,    1,16'hA0A0, 0,0);
        add(1,1,0,9'h012,2'd0,0,16'h0,      1,0,0,0,9'h000,16'h0,    1,16'hB1B1, 1,0);
        add(1,0,0,9'h000,2'd0,0,16'h0,      0,1,0,0,9'h012,16'h0,    0,16'h0,    0,0);
        add(1,0,0,9'h000,2'd0,0,16'h0,      1,0,0,0,9'h000,16'h0,    1,16'hC2C2, 1,0);
        add_idle();
        // Reset asserted during the 2nd beat of a 4-beat read.
        add(1,1,0,9'h010,2'd3,0,16'h0,      1,0,0,0,9'h000,16'h0,    0,16'h0,    0,0);
        add(1,0,0,9'h000,2'd0,0,16'h0,      0,1,0,0,9'h010,16'h0,    0,16'h0,    0,0);
        add(0,0,0,9'h000,2'd0,0,16'h0,      0,1,0,0,9'h011,16'h0,    1,16'hA0A0, 0,0);
        add_idle();
        add_idle();

        rst_b = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wvalid = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            #2;
            rst_b = tbl[i].rst_b; req_valid = tbl[i].rv; req_we = tbl[i].we;
            req_addr = tbl[i].addr; req_len = tbl[i].len;
            wvalid = tbl[i].wv; wdata = tbl[i].wd;
            #2;
            got = {req_ready, mem_read, mem_write, wready, rvalid, done, err, mem_addr, mem_din};
            exp = {tbl[i].rdy, tbl[i].rd, tbl[i].wr, tbl[i].wrdy, tbl[i].rval, tbl[i].done,
                   tbl[i].err, tbl[i].maddr, tbl[i].din};
            n_vec++;
            if (got !== exp || rdata !== tbl[i].rdat || (mem_read && mem_write)) begin
                n_bad++;
                $display("FAIL vec%0d: got rdy/rd/wr/wrdy/rv/dn/er=%b%b%b%b%b%b%b addr=%03h din=%04h rdata=%04h; expected %b%b%b%b%b%b%b addr=%03h din=%04h rdata=%04h",
                         i, req_ready, mem_read, mem_write, wready, rvalid, done, err, mem_addr, mem_din, rdata,
                         tbl[i].rdy, tbl[i].rd, tbl[i].wr, tbl[i].wrdy, tbl[i].rval, tbl[i].done,
                         tbl[i].err, tbl[i].maddr, tbl[i].din, tbl[i].rdat);
            end
            @(posedge clk);
        end

        check_mem("wr_beat0", 9'h1F0, 16'h1111);
        check_mem("wr_beat1", 9'h1F1, 16'h2222);
        check_mem("wr_no_spill", 9'h1F2, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter AW, default 9, memory address width (512 words).
REQ-002 Parameter DW, default 16, data word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_b  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  burst request offered by CPU.
REQ-006 req_ready  output  1  controller accepts a request this cycle.
REQ-007 req_we  input  1  1 = write burst, 0 = read burst.
REQ-008 req_addr  input  AW  burst start address.
REQ-009 req_len  input  2  beats minus one (1..4 beats).
REQ-010 wvalid  input  1  write beat data present.
REQ-011 wready  output  1  controller consumes a write beat this cycle.
REQ-012 wdata  input  DW  write beat data.
REQ-013 rvalid  output  1  read beat data valid; CPU always accepts it.
REQ-014 rdata  output  DW  read beat data.
REQ-015 done  output  1  one-cycle pulse on the final beat of a burst.
REQ-016 err  output  1  one-cycle pulse on a rejected request (MEM_WRAP_ERR_EN only).
REQ-017 mem_write, mem_read  output  1 each  memory strobes, active high.
REQ-018 mem_addr  output  AW  memory address; mem_din  output  DW  memory write data.
REQ-019 mem_dout  input  DW  memory read data, valid the cycle after mem_read.

Function
REQ-020 States: IDLE, WR, RD; req_ready SHALL be 1 only in IDLE.
REQ-021 On req_valid&&req_ready at edge T: latch addr, len, and we; clear the beat counter; go to WR or RD at T.
REQ-022 RD: mem_read=1, mem_addr=base+beat, one beat per cycle; after beat len issues, go to IDLE.
REQ-023 rvalid SHALL be 1 the cycle after each mem_read (registered pending flag); rdata=mem_dout in that cycle.
REQ-024 Read latency: the first rvalid is 2 cycles after the accept edge; beats are back-to-back with no gaps.
REQ-025 WR: wready=1; mem_write=wvalid; mem_din=wdata; mem_addr=base+beat; the beat advances only when wvalid=1.
REQ-026 WR with wvalid=0: no memory access; state and beat hold indefinitely.
REQ-027 After the write beat len is accepted, go to IDLE; done=1 in that same cycle.
REQ-028 For reads, done=1 together with the final rvalid, which may overlap an IDLE cycle that accepts a new request.
REQ-029 mem_read and mem_write SHALL never both be 1; both SHALL be 0 in IDLE.
REQ-030 Address arithmetic is AW-bit modulo 2^AW (511+1 -> 0) unless MEM_WRAP_ERR_EN is defined.
REQ-031 A request arriving while not in IDLE is not accepted; the requester holds it.

Reset
REQ-032 At an edge with rst_b=0: state=IDLE, beat=0, pending flag=0.
REQ-033 Reset drives all outputs to 0 except req_ready=1, including mid-burst; an aborted burst produces no done.

Configuration
REQ-034 Macro MEM_WRAP_ERR_EN defined: a request with req_addr+req_len > 2^AW-1 is accepted and then dropped in IDLE. The drop pulses err for 1 cycle, issues no memory access, and produces no done.
REQ-035 Macro MEM_WRAP_ERR_EN undefined: addresses wrap modulo 2^AW and err is tied to 0.

Structure
REQ-036 Package mem_ctrl_pkg holds the state enum, the AW/DW defaults, and the beat-count width constant.
REQ-037 Sub-module mem_burst_cnt: latched base plus beat counter, producing the current address and a last-beat flag.

Verification
REQ-038 Read, addr 0x010, len 3, mem[0x010..0x013]=A,B,C,D -> rvalid at accept+2..+5 with A,B,C,D; done with D.
REQ-039 Write, addr 0x1F0, len 1, wvalid gapped (1,0,1) -> mem_write only on the valid cycles; mem[0x1F0]/[0x1F1] updated; done on the 2nd beat.
REQ-040 Read, addr 0x1FE, len 3 with macro undefined -> addresses 0x1FE, 0x1FF, 0x000, 0x001; with macro defined -> err pulse, no strobes.
REQ-041 rst_b=0 during the 2nd beat of a 4-beat read -> next cycle: all strobes 0, rvalid 0, req_ready 1, no done.
REQ-042 New read request held during the final-rvalid cycle of a previous read -> accepted then; no cycle has both strobes high; data order is preserved.
